// File: rtl/pe_mac_pipe.sv
// Purpose: fixed-point PE. Computes signed ain x RAM[addr] (>>> FRAC_W) plus a bias,
//          either per beat (mode 0) or accumulated over a vector ended by last (mode 1).
// Latency: result 3 cycles after the accepted beat. No backpressure: one beat per cycle, always accepted.
// Ports: aclk/areset (sync, active-high); ain/cin operands; din/addr/we RAM write port;
//        addr/valid operand-B read; last/mode vector control; dvalid/dout/sat result; err collision pulse.
module pe_mac_pipe #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 8,
  parameter int L_RAM_SIZE = 6,
  parameter int GUARD_W    = 8,
  parameter int SAT        = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_W-1:0]     ain,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W-1:0]     cin,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic                  we,
  input  logic                  valid,
  input  logic                  last,
  input  logic                  mode,
  output logic                  dvalid,
  output logic [DATA_W-1:0]     dout,
  output logic                  sat,
  output logic                  err
);

  localparam int ACC_W  = DATA_W + GUARD_W;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {IDLE, ACCUM} state_e;

  // Local operand RAM (not reset) and its registered read port.
  logic [DATA_W-1:0] peram [2**L_RAM_SIZE];
  logic [DATA_W-1:0] b_q;

  // Stage 1: operands registered alongside the RAM read.
  logic              s1_vld_q;
  logic [DATA_W-1:0] a1_q, c1_q;
  logic              last1_q, mode1_q;
  logic              err_q;

  // Stage 2: scaled product.
  logic                     s2_vld_q;
  logic [ACC_W-1:0]         p_q;
  logic [DATA_W-1:0]        c2_q;
  logic                     last2_q, mode2_q;
  logic signed [PROD_W-1:0] a_ext, b_ext, prod;

  // Stage 3: accumulator, FSM and registered outputs.
  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum, c_ext;
  logic              fire;
  logic              dvalid_q, dvalid_d, sat_q, sat_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  // Returns {clamped, value}. Overflow means the bits above the DATA_W sign bit
  // are not all copies of it.
  function automatic logic [DATA_W:0] fit(input logic [ACC_W-1:0] x);
    logic ovf;
    ovf = ~((&x[ACC_W-1:DATA_W-1]) | ~(|x[ACC_W-1:DATA_W-1]));
    if ((SAT != 0) && ovf)
      fit = x[ACC_W-1] ? {2'b11, {(DATA_W-1){1'b0}}} : {2'b10, {(DATA_W-1){1'b1}}};
    else
      fit = {1'b0, x[DATA_W-1:0]};
  endfunction

  // Write wins over a read in the same cycle.
  always_ff @(posedge aclk) begin
    if (we)
      peram[addr] <= din;
    else if (valid)
      b_q <= peram[addr];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld_q <= 1'b0;
      err_q    <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= valid & ~we;
      err_q    <= valid & we;
      s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (valid && !we) begin
      a1_q    <= ain;
      c1_q    <= cin;
      last1_q <= last;
      mode1_q <= mode;
    end
    if (s1_vld_q) begin
      p_q     <= ACC_W'(prod >>> FRAC_W);
      c2_q    <= c1_q;
      last2_q <= last1_q;
      mode2_q <= mode1_q;
    end
  end

  // Full-width signed product; the arithmetic shift floors toward -inf.
  assign a_ext = {{DATA_W{a1_q[DATA_W-1]}}, a1_q};
  assign b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Mode and bias only matter on the first beat; in ACCUM they are ignored.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dvalid_d = 1'b0;
    dout_d   = dout_q;
    sat_d    = 1'b0;
    fire     = 1'b0;
    sum      = '0;
    c_ext    = {{GUARD_W{c2_q[DATA_W-1]}}, c2_q};
    if (s2_vld_q) begin
      case (state_q)
        IDLE: begin
          sum = c_ext + p_q;
          if (!mode2_q || last2_q) begin
            fire = 1'b1;
          end else begin
            acc_d   = sum;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          sum = acc_q + p_q;
          if (last2_q) begin
            fire    = 1'b1;
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = sum;
          end
        end
      endcase
    end
    if (fire) begin
      dvalid_d        = 1'b1;
      {sat_d, dout_d} = fit(sum);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
      sat_q    <= sat_d;
    end
  end

  assign dvalid = dvalid_q;
  assign dout   = dout_q;
  assign sat    = sat_q;
  assign err    = err_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
module tb_pe_mac_pipe;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] ain = 32'h0, din = 32'h0, cin = 32'h0;
  logic [5:0]  addr = 6'd0;
  logic        we = 1'b0, valid = 1'b0, last = 1'b0, mode = 1'b0;
  logic        dvalid, sat, err, dvalid1, sat1, err1;
  logic [31:0] dout, dout1;

  always #5 aclk = ~aclk;

  pe_mac_pipe #(.SAT(1)) u_sat (
    .aclk(aclk), .areset(areset), .ain(ain), .din(din), .cin(cin), .addr(addr),
    .we(we), .valid(valid), .last(last), .mode(mode),
    .dvalid(dvalid), .dout(dout), .sat(sat), .err(err)
  );

  pe_mac_pipe #(.SAT(0)) u_wrap (
    .aclk(aclk), .areset(areset), .ain(ain), .din(din), .cin(cin), .addr(addr),
    .we(we), .valid(valid), .last(last), .mode(mode),
    .dvalid(dvalid1), .dout(dout1), .sat(sat1), .err(err1)
  );

  typedef struct {
    logic [31:0] d0;
    logic        s0;
    logic [31:0] d1;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0, n_fail = 0;
  int          ncyc = 0, dv_cnt = 0, err_cnt = 0;
  logic [31:0] mram [64];

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  // Reference model: Q24.8 product floored toward -inf, then saturating or wrapping fit.
  function automatic longint prod(input logic [31:0] a, input logic [31:0] b);
    prod = (longint'($signed(a)) * longint'($signed(b))) >>> 8;
  endfunction

  function automatic logic [32:0] fit_s(input longint x);
    if (x > MAXV)      fit_s = {1'b1, 32'h7FFFFFFF};
    else if (x < MINV) fit_s = {1'b1, 32'h80000000};
    else               fit_s = {1'b0, x[31:0]};
  endfunction

  function automatic logic [31:0] fit_w(input longint x);
    fit_w = x[31:0];
  endfunction

  task automatic push_exp(input longint v, input int cyc);
    exp_t e;
    {e.s0, e.d0} = fit_s(v);
    e.d1  = fit_w(v);
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(posedge aclk); #1;
    areset = 1'b0; we = 1'b1; valid = 1'b0; addr = a; din = d;
    mram[a] = d;
  endtask

  task automatic beat(input logic [31:0] a, input logic [5:0] ad, input logic [31:0] c,
                      input logic l, input logic m);
    @(posedge aclk); #1;
    areset = 1'b0; we = 1'b0; valid = 1'b1;
    ain = a; addr = ad; cin = c; last = l; mode = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      areset = 1'b0; we = 1'b0; valid = 1'b0; last = 1'b0;
    end
  endtask

  // Scoreboard: every result strobe is popped and compared, including its arrival cycle.
  always @(negedge aclk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (err === 1'b1) err_cnt = err_cnt + 1;
    if (dvalid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_dvalid cyc=%0d got dout=%h, expected no result", ncyc, dout);
      end else begin
        e = exp_q.pop_front();
        n_checks = n_checks + 1;
        if (dout !== e.d0 || sat !== e.s0) begin
          n_fail = n_fail + 1;
          $display("FAIL result_sat got dout=%h sat=%b, expected dout=%h sat=%b", dout, sat, e.d0, e.s0);
        end
        n_checks = n_checks + 1;
        if (dvalid1 !== 1'b1 || dout1 !== e.d1 || sat1 !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL result_wrap got dvalid=%b dout=%h sat=%b, expected 1 %h 0", dvalid1, dout1, sat1, e.d1);
        end
        n_checks = n_checks + 1;
        if (ncyc != e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL latency got cycle %0d, expected cycle %0d", ncyc, e.cyc);
        end
      end
    end
  end

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_checks = n_checks + 1;
    if (dvalid !== 1'b0 || dvalid1 !== 1'b0) begin
      n_fail = n_fail + 1; $display("FAIL reset_dvalid got %b/%b, expected 0", dvalid, dvalid1);
    end
    n_checks = n_checks + 1;
    if (dout !== 32'h0) begin
      n_fail = n_fail + 1; $display("FAIL reset_dout got %h, expected 0", dout);
    end
    n_checks = n_checks + 1;
    if (sat !== 1'b0) begin
      n_fail = n_fail + 1; $display("FAIL reset_sat got %b, expected 0", sat);
    end
    n_checks = n_checks + 1;
    if (err !== 1'b0) begin
      n_fail = n_fail + 1; $display("FAIL reset_err got %b, expected 0", err);
    end
  endtask

  task automatic test_mode0;
    int d0;
    d0 = dv_cnt;
    wr(6'd5, 32'h00000300);
    beat(32'h00000200, 6'd5, 32'h00000100, 1'b0, 1'b0);
    push_exp(64'sh100 + prod(32'h200, mram[5]), ncyc + 4);
    idle(6);
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL mode0_count got %0d results, %0d pending, expected 1 and 0", dv_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_mode1;
    int d0;
    longint acc;
    d0 = dv_cnt;
    wr(6'd0, 32'h100); wr(6'd1, 32'h200); wr(6'd2, 32'h300); wr(6'd3, 32'h400);
    // cin and mode changes after the first beat must be ignored.
    beat(32'h100, 6'd0, 32'h080, 1'b0, 1'b1);  acc = 64'sh80 + prod(32'h100, mram[0]);
    beat(32'h100, 6'd1, 32'h7777, 1'b0, 1'b1); acc = acc + prod(32'h100, mram[1]);
    beat(32'h100, 6'd2, 32'h1234, 1'b0, 1'b0); acc = acc + prod(32'h100, mram[2]);
    beat(32'h100, 6'd3, 32'h0, 1'b1, 1'b1);    acc = acc + prod(32'h100, mram[3]);
    push_exp(acc, ncyc + 4);
    // Back-to-back vector with no bubble.
    beat(32'h200, 6'd0, 32'h010, 1'b0, 1'b1);  acc = 64'sh10 + prod(32'h200, mram[0]);
    beat(32'h200, 6'd1, 32'h099, 1'b1, 1'b1);  acc = acc + prod(32'h200, mram[1]);
    push_exp(acc, ncyc + 4);
    // Single-beat vector outputs straight from IDLE.
    beat(32'h100, 6'd2, 32'h005, 1'b1, 1'b1);
    push_exp(64'sh5 + prod(32'h100, mram[2]), ncyc + 4);
    idle(6);
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 3 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL mode1_count got %0d results, %0d pending, expected 3 and 0", dv_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_signed_sat;
    int d0;
    d0 = dv_cnt;
    wr(6'd6, 32'h00000180); wr(6'd7, 32'h00000200);
    beat(32'hFFFFFE00, 6'd6, 32'h0, 1'b0, 1'b0);
    push_exp(prod(32'hFFFFFE00, mram[6]), ncyc + 4);
    beat(32'h7FFFFF00, 6'd7, 32'h0, 1'b0, 1'b0);
    push_exp(prod(32'h7FFFFF00, mram[7]), ncyc + 4);
    beat(32'h80000000, 6'd7, 32'h0, 1'b0, 1'b0);
    push_exp(prod(32'h80000000, mram[7]), ncyc + 4);
    beat(32'hFFFFFF00, 6'd7, 32'h7FFFFFFF, 1'b1, 1'b0);
    push_exp(64'sh7FFFFFFF + prod(32'hFFFFFF00, mram[7]), ncyc + 4);
    idle(6);
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 4 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL signed_count got %0d results, %0d pending, expected 4 and 0", dv_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_collision;
    int d0, e0;
    longint acc;
    d0 = dv_cnt;
    wr(6'd8, 32'h100); wr(6'd9, 32'h100);
    e0 = err_cnt;
    beat(32'h100, 6'd8, 32'h040, 1'b0, 1'b1);
    acc = 64'sh40 + prod(32'h100, mram[8]);
    // Colliding beat carries last=1; it must neither terminate nor add to the vector.
    @(posedge aclk); #1;
    we = 1'b1; valid = 1'b1; din = 32'h500; addr = 6'd9; ain = 32'h100; cin = 32'h0; last = 1'b1;
    mram[9] = 32'h500;
    beat(32'h100, 6'd9, 32'h0, 1'b1, 1'b1);
    acc = acc + prod(32'h100, mram[9]);
    push_exp(acc, ncyc + 4);
    @(negedge aclk);
    n_checks = n_checks + 1;
    if (err !== 1'b1 || err1 !== 1'b1) begin
      n_fail = n_fail + 1; $display("FAIL collision_err_timing got %b/%b, expected 1", err, err1);
    end
    idle(6);
    n_checks = n_checks + 1;
    if (err_cnt - e0 != 1) begin
      n_fail = n_fail + 1; $display("FAIL collision_err_count got %0d pulses, expected 1", err_cnt - e0);
    end
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL collision_count got %0d results, %0d pending, expected 1 and 0", dv_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = dv_cnt;
    wr(6'd10, 32'h300); wr(6'd11, 32'h300); wr(6'd12, 32'h280);
    beat(32'h100, 6'd10, 32'h050, 1'b0, 1'b1);
    beat(32'h100, 6'd11, 32'h0, 1'b0, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1; valid = 1'b0; we = 1'b0;
    beat(32'h200, 6'd12, 32'h0, 1'b1, 1'b1);
    push_exp(prod(32'h200, mram[12]), ncyc + 4);
    idle(6);
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_count got %0d results, %0d pending, expected 1 and 0", dv_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_zero;
    int d0;
    d0 = dv_cnt;
    wr(6'd14, 32'h0);
    beat(32'h0, 6'd14, 32'h0, 1'b1, 1'b0);
    push_exp(64'sh0, ncyc + 4);
    idle(6);
    n_checks = n_checks + 1;
    if (dv_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL zero_count got %0d results, %0d pending, expected 1 and 0", dv_cnt - d0, exp_q.size());
    end
    d0 = dv_cnt;
    idle(100);
    n_checks = n_checks + 1;
    if (dv_cnt != d0) begin
      n_fail = n_fail + 1; $display("FAIL quiet_dvalid got %0d results, expected 0", dv_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_signed_sat();
    test_collision();
    test_reset_mid();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_mac_pipe.md
Name: pe_mac_pipe

Overview:
- Parametrised fixed-point processing element: signed multiply of streamed operand `ain` by an operand read from a local block RAM, plus a bias `cin`.
- Two modes: per-beat element MAC, or dot-product accumulation over a vector terminated by `last`.
- Deterministic, fixed-latency valid pipeline; no data-dependent valid generation.
- Sits in the PE array behind the matrix controller, which loads each PE's RAM and then streams operands to it.

Parameters:
- DATA_W, 32: operand/result width, two's-complement fixed point.
- FRAC_W, 8: fractional bits in all operands and results (default format Q24.8).
- L_RAM_SIZE, 6: local RAM address width; depth is 2**L_RAM_SIZE.
- GUARD_W, 8: extra accumulator integer bits above DATA_W.
- SAT, 1: 1 = saturate the result to DATA_W; 0 = wrap (truncate MSBs).

Ports:
- aclk, in, 1: clock; all state changes on the rising edge.
- areset, in, 1: synchronous reset, active-high.
- ain, in, DATA_W: streamed operand A.
- din, in, DATA_W: RAM write data.
- cin, in, DATA_W: bias; sampled on the first beat of a vector (mode 1) or on every beat (mode 0).
- addr, in, L_RAM_SIZE: RAM address for the write or the operand-B read.
- we, in, 1: RAM write enable.
- valid, in, 1: compute beat qualifier.
- last, in, 1: final beat of the vector; ignored in mode 0.
- mode, in, 1: 0 = element MAC; 1 = dot-product accumulate.
- dvalid, out, 1: result strobe, one cycle wide.
- dout, out, DATA_W: result.
- sat, out, 1: this result was clamped; valid only with dvalid.
- err, out, 1: one-cycle pulse when a beat is dropped by a we/valid collision.

Behaviour:
- Reset (areset=1 at an edge):
  - dvalid, dout, sat and err go to 0.
  - All pipeline valid bits and the accumulator are cleared; FSM returns to IDLE.
  - RAM contents are NOT cleared.
  - Reset asserted mid-vector discards the partial sum; no dvalid is produced for that vector.
- RAM: single port, registered read.
  - we=1: peram[addr] <= din.
  - we=0 and valid=1: b_q <= peram[addr].
- Collision (we=1 and valid=1): write wins, the beat is dropped, err pulses on the next cycle, and FSM and accumulator are unchanged.
- Pipeline; accepted beat at cycle T (valid=1, we=0):
  - T+1: b_q is available; ain, cin, last and mode are registered alongside it.
  - T+2: p_q = (signed ain × signed b_q) >>> FRAC_W, with a 2*DATA_W-bit product, arithmetic shift, truncation toward -inf.
  - T+3: accumulate/add stage updates; dvalid/dout are registered outputs. Result latency is 3 cycles.
- A new beat may be accepted every cycle (throughput 1 beat/cycle); back-to-back vectors need no bubble.
- Accumulator width is DATA_W+GUARD_W, with the sign-extended p_q added.
- Mode 0: each beat produces dvalid=1 at T+3 with dout = fit(p_q + cin).
- Mode 1 FSM:
  - IDLE: an accepted beat sets acc = cin + p_q, then → ACCUM. If that beat has last=1, it outputs immediately and stays in IDLE.
  - ACCUM: each beat sets acc += p_q. A beat with last=1 outputs fit(acc + p_q) at T+3, clears acc and → IDLE.
  - mode and cin are captured on the first beat of a vector; changes to them mid-vector are ignored until after last.
- fit(x):
  - SAT=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set sat=1 when clamped.
  - SAT=0: take x[DATA_W-1:0]; sat is always 0.
- GUARD_W overflow of the accumulator wraps silently. Verification must not rely on it.
- A zero product produces dvalid=1 exactly as any other product does.

Test Plan:
- Mode 0: RAM[5]=0x00000300 (3.0); ain=0x00000200 (2.0), cin=0x00000100 (1.0), addr=5, one valid beat → exactly one dvalid 3 cycles later, dout=0x00000700, sat=0.
- Mode 1: RAM[0..3]=0x100, 0x200, 0x300, 0x400; ain=0x100 on 4 consecutive beats, cin=0x080, last on beat 4 → single dvalid 3 cycles after beat 4, dout=0x00000A80; next vector starting on the following cycle is summed independently.
- Signed and saturation cases:
  - ain=0xFFFFFE00 (-2.0), b=0x00000180 (1.5), cin=0 → dout=0xFFFFFD00.
  - ain=0x7FFFFF00, b=0x00000200, SAT=1 → dout=0x7FFFFFFF, sat=1.
  - Same inputs with SAT=0 → dout=0xFFFFFE00, sat=0.
- Collision: we=1 and valid=1 in the same cycle → RAM written, err pulses once, no dvalid for that beat, an in-progress vector sum is unaffected.
- Reset mid-vector: 2 of 4 beats accepted, then areset for 1 cycle → no dvalid. A new 1-beat vector with last=1 and RAM preserved → dout equals that beat alone.
- Zero operands: ain=0, b=0, cin=0 → dvalid=1 at T+3 with dout=0; with no valid, dvalid stays 0 for 100 cycles.
